// File: rtl/sub_seq.sv
// Byte-serial subtractor: y = a - b - bin, one byte per cycle with rippled borrow.
// Optional signed-overflow output enabled by defining SUB_SEQ_OVF_EN.
module sub_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   y,
  output logic                  bout
`ifdef SUB_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [KW-1:0]   k_q, k_d;
  logic            brw_q, brw_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    y_q, y_d;
  logic            bout_q, bout_d;
`ifdef SUB_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [8:0]      diff;

  // Current byte slice and its 8-bit difference; diff[8] is the byte's borrow-out.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (k_q == KW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
    diff = {1'b0, a_byte} - {1'b0, b_byte} - {8'd0, brw_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    brw_d   = brw_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    y_d     = y_q;
    bout_d  = bout_q;
`ifdef SUB_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          k_d     = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NBYTES); i++) begin
          if (k_q == KW'(i)) res_d[8*i +: 8] = diff[7:0];
        end
        brw_d = diff[8];
        if (k_q == KW'(NBYTES - 1)) begin
          // Last byte: publish the full result together with the final borrow.
          state_d = DONE;
          done_d  = 1'b1;
          k_d     = '0;
          y_d     = res_d;
          bout_d  = diff[8];
`ifdef SUB_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] != b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
`endif
        end else begin
          k_d    = k_q + KW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      bout_q  <= bout_d;
`ifdef SUB_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign bout = bout_q;
`ifdef SUB_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
